signal_mux_xfade: RTL and testbench

Parametrised successor of the generated-signal multiplexer. Selects one of N_CH signed sample channels for the FIR input path. On a channel change it performs a linear crossfade over 2^LOG2_XFADE enabled samples instead of a hard switch, which keeps step transients out of the filter. It sits between the signal generators and fir_filter and is clocked by the system clock, gated by a sample strobe.

---
 rtl/signal_mux_xfade_pkg.sv | 26 ++
 rtl/signal_mux_xfade_mixer.sv | 38 +++
 rtl/signal_mux_xfade.sv | 133 +++++++++++++
 tb/tb_signal_mux_xfade.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/signal_mux_xfade_pkg.sv
// Shared types and width helpers for the crossfading signal multiplexer.
package signal_mux_pkg;

    typedef enum logic {
        ST_STEADY = 1'b0,
        ST_FADE   = 1'b1
    } state_t;

    function automatic int nb_diff(input int nb_data);
        return nb_data + 1;
    endfunction

    function automatic int nb_prod(input int nb_data, input int log2_xfade);
        return nb_data + log2_xfade + 2;
    endfunction

    function automatic int nb_k(input int log2_xfade);
        return log2_xfade + 1;
    endfunction

    // Widths at the default configuration (NB_DATA=8, LOG2_XFADE=2).
    localparam int NB_DIFF = nb_diff(8);
    localparam int NB_PROD = nb_prod(8, 2);
    localparam int NB_K    = nb_k(2);

endpackage

// File: rtl/signal_mux_xfade_mixer.sv
// Combinational linear blend: a + ((b - a) * k) >>> LOG2_XFADE.
module xfade_mixer
    import signal_mux_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int LOG2_XFADE = 2
) (
    input  logic signed [NB_DATA-1:0]           a,
    input  logic signed [NB_DATA-1:0]           b,
    input  logic        [nb_k(LOG2_XFADE)-1:0]  k,
    output logic signed [NB_DATA-1:0]           mix
);

    localparam int DIFF_W = nb_diff(NB_DATA);
    localparam int PROD_W = nb_prod(NB_DATA, LOG2_XFADE);
    localparam int K_W    = nb_k(LOG2_XFADE);

    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] diff_x;
    logic signed [PROD_W-1:0] k_x;
    logic signed [PROD_W-1:0] a_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] scaled;
    logic signed [PROD_W-1:0] sum;

    always_comb begin
        diff   = {b[NB_DATA-1], b} - {a[NB_DATA-1], a};
        diff_x = {{(PROD_W-DIFF_W){diff[DIFF_W-1]}}, diff};
        k_x    = {{(PROD_W-K_W){1'b0}}, k};
        a_x    = {{(PROD_W-NB_DATA){a[NB_DATA-1]}}, a};
        prod   = diff_x * k_x;
        scaled = prod >>> LOG2_XFADE;
        sum    = scaled + a_x;
        // Blend always lies between a and b, so plain truncation is exact.
        mix    = sum[NB_DATA-1:0];
    end

endmodule

// File: rtl/signal_mux_xfade.sv
// Channel selector feeding the FIR path; crossfades linearly on channel change.
module signal_mux_xfade
    import signal_mux_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int N_CH       = 4,
    parameter int NB_SEL     = 2,
    parameter int LOG2_XFADE = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_en,
    input  logic [NB_SEL-1:0]         i_sel,
    input  logic [N_CH*NB_DATA-1:0]   i_signals,
    output logic signed [NB_DATA-1:0] o_signal,
    output logic                      o_valid,
    output logic                      o_busy,
    output logic [NB_SEL-1:0]         o_active_sel
);

    localparam int K_W    = nb_k(LOG2_XFADE);
    localparam int N_SLOT = 2 ** NB_SEL;
    localparam logic [K_W-1:0]    K_ONE  = K_W'(1);
    localparam logic [K_W-1:0]    K_TWO  = K_W'(2);
    localparam logic [K_W-1:0]    K_LAST = K_W'(2 ** LOG2_XFADE);
    localparam logic [NB_SEL:0]   N_CH_X = (NB_SEL+1)'(N_CH);

    state_t                    state, state_next;
    logic [NB_SEL-1:0]         active, active_next;
    logic [NB_SEL-1:0]         src, src_next;
    logic [NB_SEL-1:0]         pending, pending_next;
    logic [K_W-1:0]            k, k_next;
    logic signed [NB_DATA-1:0] sample, sample_next;
    logic                      valid;
    logic                      sel_ok;

    logic signed [NB_DATA-1:0] ch [N_SLOT];
    logic signed [NB_DATA-1:0] mix_a, mix_b, mix_out;
    logic [K_W-1:0]            mix_k;

    for (genvar c = 0; c < N_SLOT; c++) begin : g_ch
        if (c < N_CH) begin : g_live
            assign ch[c] = i_signals[c*NB_DATA +: NB_DATA];
        end else begin : g_unused
            assign ch[c] = '0;
        end
    end

    assign sel_ok = ({1'b0, i_sel} < N_CH_X);

    // In STEADY the mixer previews the first fade sample toward the pending channel.
    always_comb begin
        if (state == ST_STEADY) begin
            mix_a = ch[active];
            mix_b = ch[pending];
            mix_k = K_ONE;
        end else begin
            mix_a = ch[src];
            mix_b = ch[active];
            mix_k = k;
        end
    end

    xfade_mixer #(
        .NB_DATA    (NB_DATA),
        .LOG2_XFADE (LOG2_XFADE)
    ) u_mixer (
        .a   (mix_a),
        .b   (mix_b),
        .k   (mix_k),
        .mix (mix_out)
    );

    always_comb begin
        state_next   = state;
        active_next  = active;
        src_next     = src;
        k_next       = k;
        sample_next  = sample;
        pending_next = sel_ok ? i_sel : pending;
        if (i_en) begin
            case (state)
                ST_STEADY: begin
                    if (pending != active) begin
                        src_next    = active;
                        active_next = pending;
                        sample_next = mix_out;
                        k_next      = K_TWO;
                        state_next  = ST_FADE;
                    end else begin
                        sample_next = ch[active];
                    end
                end
                ST_FADE: begin
                    sample_next = mix_out;
                    if (k == K_LAST) begin
                        state_next = ST_STEADY;
                        k_next     = '0;
                    end else begin
                        k_next = k + K_ONE;
                    end
                end
                default: state_next = ST_STEADY;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state   <= ST_STEADY;
            active  <= '0;
            src     <= '0;
            pending <= '0;
            k       <= '0;
            sample  <= '0;
            valid   <= 1'b0;
        end else begin
            state   <= state_next;
            active  <= active_next;
            src     <= src_next;
            pending <= pending_next;
            k       <= k_next;
            sample  <= sample_next;
            valid   <= i_en;
        end
    end

    assign o_signal     = sample;
    assign o_valid      = valid;
    assign o_busy       = (state == ST_FADE);
    assign o_active_sel = active;

endmodule

// File: tb/tb_signal_mux_xfade.sv
// Directed plus randomized checks of the crossfading mux against an integer reference.
module tb_signal_mux_xfade;

    localparam int L  = 2;
    localparam int XF = 1 << L;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic              en0 = 1'b0, en1 = 1'b0;
    logic [1:0]        sel0 = '0, sel1 = '0;
    logic [31:0]       sig0;
    logic [23:0]       sig1;
    logic signed [7:0] out0, out1;
    logic              valid0, valid1, busy0, busy1;
    logic [1:0]        asel0, asel1;

    int tests = 0;
    int fails = 0;

    int chv [2][4];
    int m_out [2], m_valid [2], m_active [2], m_src [2], m_pending [2], m_k [2], m_fading [2];

    always #5 clk = ~clk;

    signal_mux_xfade #(.NB_DATA(8), .N_CH(4), .NB_SEL(2), .LOG2_XFADE(L)) dut0 (
        .i_clock(clk), .i_reset(rst_n), .i_en(en0), .i_sel(sel0), .i_signals(sig0),
        .o_signal(out0), .o_valid(valid0), .o_busy(busy0), .o_active_sel(asel0));

    signal_mux_xfade #(.NB_DATA(8), .N_CH(3), .NB_SEL(2), .LOG2_XFADE(L)) dut1 (
        .i_clock(clk), .i_reset(rst_n), .i_en(en1), .i_sel(sel1), .i_signals(sig1),
        .o_signal(out1), .o_valid(valid1), .o_busy(busy1), .o_active_sel(asel1));

    always_comb begin
        for (int c = 0; c < 4; c++) sig0[c*8 +: 8] = 8'(chv[0][c]);
        for (int c = 0; c < 3; c++) sig1[c*8 +: 8] = 8'(chv[1][c]);
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Floor of a + (b-a)*k/2^L, done with ordinary integer division.
    function automatic int ref_mix(input int a, input int b, input int k);
        int p;
        p = (b - a) * k;
        if (p >= 0) return a + p / XF;
        return a - ((-p + XF - 1) / XF);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 0; m_valid[i] = 0; m_active[i] = 0; m_src[i] = 0;
            m_pending[i] = 0; m_k[i] = 0; m_fading[i] = 0;
        end
    endtask

    task automatic model_step(input int id, input int nch, input int en, input int sel);
        m_valid[id] = en;
        if (en != 0) begin
            if (m_fading[id] == 0) begin
                if (m_pending[id] != m_active[id]) begin
                    m_src[id]    = m_active[id];
                    m_active[id] = m_pending[id];
                    m_out[id]    = ref_mix(chv[id][m_src[id]], chv[id][m_active[id]], 1);
                    m_k[id]      = 2;
                    m_fading[id] = 1;
                end else begin
                    m_out[id] = chv[id][m_active[id]];
                end
            end else begin
                m_out[id] = ref_mix(chv[id][m_src[id]], chv[id][m_active[id]], m_k[id]);
                if (m_k[id] == XF) m_fading[id] = 0;
                m_k[id]++;
            end
        end
        if (sel < nch) m_pending[id] = sel;
    endtask

    task automatic step();
        int e0, e1, s0, s1;
        e0 = int'(en0); e1 = int'(en1); s0 = int'(sel0); s1 = int'(sel1);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, 4, e0, s0);
            model_step(1, 3, e1, s1);
        end
        check("out0", int'(out0), m_out[0]);
        check("valid0", int'(valid0), m_valid[0]);
        check("busy0", int'(busy0), m_fading[0]);
        check("asel0", int'(asel0), m_active[0]);
        check("out1", int'(out1), m_out[1]);
        check("valid1", int'(valid1), m_valid[1]);
        check("busy1", int'(busy1), m_fading[1]);
        check("asel1", int'(asel1), m_active[1]);
    endtask

    task automatic plan_channels();
        chv[0][0] = 0; chv[0][1] = 100; chv[0][2] = -100; chv[0][3] = 40;
        chv[1][0] = 0; chv[1][1] = 100; chv[1][2] = -100; chv[1][3] = 0;
    endtask

    int exp_up [4]   = '{25, 50, 75, 100};
    int exp_dn [4]   = '{50, 0, -50, -100};
    int exp_q  [7]   = '{50, 75, 100, 50, 0, -50, -100};
    int busy_up [4]  = '{1, 1, 1, 0};

    initial begin
        plan_channels();
        model_reset();
        #1;
        check("rst_out", int'(out0), 0);
        check("rst_valid", int'(valid0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_asel", int'(asel0), 0);
        step();
        rst_n = 1'b1;
        en0 = 1'b1; en1 = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // 0 -> 1 ramp
        sel0 = 2'd1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("up_out", int'(out0), exp_up[i]);
            check("up_busy", int'(busy0), busy_up[i]);
            check("up_asel", int'(asel0), 1);
        end
        step();
        check("up_hold", int'(out0), 100);

        // 1 -> 2, negative difference
        sel0 = 2'd2;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("dn_out", int'(out0), exp_dn[i]);
        end
        step();
        check("dn_hold", int'(out0), -100);

        // back to 0, then queue requests during a 0 -> 1 fade
        sel0 = 2'd0;
        for (int i = 0; i < 6; i++) step();
        sel0 = 2'd1;
        step();
        step();
        check("q_first", int'(out0), 25);
        sel0 = 2'd3;
        step();
        check("q_seq", int'(out0), exp_q[0]);
        sel0 = 2'd2;
        for (int i = 1; i < 7; i++) begin
            step();
            check("q_seq", int'(out0), exp_q[i]);
            check("q_not3", int'(asel0 == 2'd3), 0);
        end

        // strobe gaps and an invalid select on the three-channel instance
        sel1 = 2'd0;
        en1 = 1'b0;
        step(); step();
        for (int i = 0; i < 30; i++) begin
            en1 = (i % 3 == 0);
            if (i == 3)  sel1 = 2'd1;
            if (i == 15) sel1 = 2'd3;
            if (i == 21) sel1 = 2'd2;
            step();
            if (i == 20) begin
                check("gap_asel", int'(asel1), 1);
                check("gap_out", int'(out1), 100);
            end
        end

        // randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            en0 = ($urandom_range(0, 3) != 0);
            en1 = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) sel0 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) sel1 = 2'($urandom_range(0, 3));
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 3) == 0) chv[0][c] = int'($urandom_range(0, 255)) - 128;
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, 3) == 0) chv[1][c] = int'($urandom_range(0, 255)) - 128;
            step();
        end

        // asynchronous reset in the middle of a fade
        plan_channels();
        en0 = 1'b1; en1 = 1'b1; sel0 = 2'd0; sel1 = 2'd0;
        for (int i = 0; i < 12; i++) step();
        sel0 = 2'd1;
        step();
        step();
        step();
        check("pre_rst", int'(out0), 50);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out", int'(out0), 0);
        check("arst_busy", int'(busy0), 0);
        check("arst_asel", int'(asel0), 0);
        check("arst_valid", int'(valid0), 0);
        model_reset();
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("rerun_out", int'(out0), exp_up[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
